// File: rtl/noc_router_pkg.sv
// Shared types and helpers for the parametrised 5-port mesh router: port indices,
// XY route selection and destination-field extraction.
package noc_router_pkg;

  localparam int unsigned NUM_PORTS   = 5;
  localparam int unsigned MAX_COORD_W = 16;

  typedef enum logic [2:0] {
    PortN = 3'd0,
    PortS = 3'd1,
    PortE = 3'd2,
    PortW = 3'd3,
    PortL = 3'd4
  } port_e;

  typedef logic [MAX_COORD_W-1:0]   coord_t;
  typedef logic [2*MAX_COORD_W-1:0] hdr_t;

  // Coordinates narrower than MAX_COORD_W arrive zero-extended.
  function automatic port_e xy_route(coord_t dst_x, coord_t dst_y, coord_t my_x, coord_t my_y);
    if (dst_x > my_x) return PortE;
    if (dst_x < my_x) return PortW;
    if (dst_y > my_y) return PortN;
    if (dst_y < my_y) return PortS;
    return PortL;
  endfunction

  function automatic coord_t coord_mask(int unsigned coord_w);
    return coord_t'((33'd1 << coord_w) - 33'd1);
  endfunction

  // hdr holds {dst_x, dst_y} right-aligned, each coord_w bits wide.
  function automatic coord_t hdr_dst_x(hdr_t hdr, int unsigned coord_w);
    return coord_t'(hdr >> coord_w) & coord_mask(coord_w);
  endfunction

  function automatic coord_t hdr_dst_y(hdr_t hdr, int unsigned coord_w);
    return coord_t'(hdr) & coord_mask(coord_w);
  endfunction

endpackage

// File: rtl/noc_in_fifo.sv
// Per-input flit FIFO. A push while full is accepted only if a pop frees the slot in
// the same cycle; otherwise the flit is silently discarded (the caller flags it).
module noc_in_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned FLIT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [FLIT_W-1:0] push_data,
  input  logic              pop,
  output logic [FLIT_W-1:0] head,
  output logic              empty,
  output logic              full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic              do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  // Storage needs no reset: empty pointers make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/noc_router_param.sv
// 5-port XY mesh router: per-input FIFOs, per-output round-robin, credit flow control,
// registered crossbar. Define ROUTER_STATS_EN to build per-output forwarded-flit counters.
module noc_router_param
  import noc_router_pkg::*;
#(
  parameter int unsigned FLIT_W  = 32,
  parameter int unsigned COORD_W = 4,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [COORD_W-1:0]                  my_x_i,
  input  logic [COORD_W-1:0]                  my_y_i,
  input  logic [NUM_PORTS-1:0]                valid_i,
  input  logic [NUM_PORTS-1:0][FLIT_W-1:0]    data_i,
  output logic [NUM_PORTS-1:0]                credit_o,
  output logic [NUM_PORTS-1:0]                valid_o,
  output logic [NUM_PORTS-1:0][FLIT_W-1:0]    data_o,
  input  logic [NUM_PORTS-1:0]                credit_i,
  output logic                                err_o,
  output logic [NUM_PORTS-1:0][15:0]          stat_cnt_o
);

  localparam int unsigned CRED_W = $clog2(DEPTH + 1);
  localparam logic [CRED_W-1:0] CredFull = CRED_W'(DEPTH);
  localparam logic [CRED_W-1:0] CredOne  = CRED_W'(1);

  logic [NUM_PORTS-1:0][FLIT_W-1:0] head;
  logic [NUM_PORTS-1:0]             empty, full, pop, drop;
  port_e                            route [NUM_PORTS];

  logic [NUM_PORTS-1:0]             gnt_valid;
  logic [NUM_PORTS-1:0][2:0]        gnt_idx;
  logic [NUM_PORTS-1:0][2:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0][CRED_W-1:0] credit_q, credit_d;
  logic                             err_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_fifo
    noc_in_fifo #(
      .DEPTH  (DEPTH),
      .FLIT_W (FLIT_W)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (valid_i[p]),
      .push_data (data_i[p]),
      .pop       (pop[p]),
      .head      (head[p]),
      .empty     (empty[p]),
      .full      (full[p])
    );
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      route[p] = xy_route(hdr_dst_x(hdr_t'(head[p][FLIT_W-1 -: 2*COORD_W]), COORD_W),
                          hdr_dst_y(hdr_t'(head[p][FLIT_W-1 -: 2*COORD_W]), COORD_W),
                          coord_t'(my_x_i), coord_t'(my_y_i));
    end
  end

  // Round-robin search starts at rr_ptr_q[o]; first matching head with credit wins.
  always_comb begin
    logic [2:0] cand;
    cand      = '0;
    gnt_valid = '0;
    gnt_idx   = '0;
    pop       = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        cand = 3'((32'(rr_ptr_q[o]) + 32'(k)) % NUM_PORTS);
        if (!gnt_valid[o] && (credit_q[o] != '0) && !empty[cand] &&
            (route[cand] == port_e'(o))) begin
          gnt_valid[o] = 1'b1;
          gnt_idx[o]   = cand;
        end
      end
      if (gnt_valid[o]) pop[gnt_idx[o]] = 1'b1;
    end
  end

  // A same-cycle pop frees the slot, so only a push into a full, non-popping FIFO drops.
  assign drop = valid_i & full & ~pop;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    credit_d = credit_q;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (gnt_valid[o]) begin
        rr_ptr_d[o] = (gnt_idx[o] == 3'(NUM_PORTS - 1)) ? 3'd0 : gnt_idx[o] + 3'd1;
      end
      case ({gnt_valid[o], credit_i[o]})
        2'b10:   credit_d[o] = credit_q[o] - CredOne;
        2'b01:   if (credit_q[o] != CredFull) credit_d[o] = credit_q[o] + CredOne;
        default: credit_d[o] = credit_q[o];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_o  <= '0;
      data_o   <= '0;
      credit_o <= '0;
      err_q    <= 1'b0;
      credit_q <= {NUM_PORTS{CredFull}};
      rr_ptr_q <= '0;
    end else begin
      credit_o <= pop;
      credit_q <= credit_d;
      rr_ptr_q <= rr_ptr_d;
      if (|drop) err_q <= 1'b1;
      for (int o = 0; o < NUM_PORTS; o++) begin
        valid_o[o] <= gnt_valid[o];
        if (gnt_valid[o]) data_o[o] <= head[gnt_idx[o]];
      end
    end
  end

  assign err_o = err_q;

`ifdef ROUTER_STATS_EN
  logic [NUM_PORTS-1:0][15:0] stat_q;

  // Counts on the grant edge, so the value tracks the number of valid_o beats seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_q <= '0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (gnt_valid[o] && (stat_q[o] != 16'hFFFF)) stat_q[o] <= stat_q[o] + 16'd1;
      end
    end
  end

  assign stat_cnt_o = stat_q;
`else
  assign stat_cnt_o = '0;
`endif

endmodule
